// File: rtl/uart_rx.sv
// UART receive front end: 2-flop RXD synchroniser, mid-bit start qualification and
// centre sampling of data/parity/stop bits, one registered VALID/FERR/PERR pulse per frame.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 TICK,
    input  logic                 RXD,
    output logic [DATA_BITS-1:0] DOUT,
    output logic                 VALID,
    output logic                 FERR,
    output logic                 PERR,
    output logic                 BUSY
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rxs_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 par_q, par_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 mid_start, bit_end, par_bad;

    assign mid_start = TICK && (cnt_q == CNT_HALF);
    assign bit_end   = TICK && (cnt_q == CNT_LAST);
    // Odd parity expects the inverse of the data XOR.
    assign par_bad   = (PARITY != 0) && (par_q != ((^shift_q) ^ (PARITY == 2)));

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= RXD;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (TICK && !rxs_q) state_d = S_START;
            S_START: if (mid_start) state_d = rxs_q ? S_IDLE : S_DATA;
            S_DATA:  if (bit_end && (bit_q == BIT_LAST))
                         state_d = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (bit_end) state_d = S_STOP;
            S_STOP:  if (bit_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        if (TICK) begin
            case (state_q)
                S_IDLE: cnt_d = '0;
                S_START: begin
                    cnt_d = mid_start ? '0 : cnt_q + 1'b1;
                    bit_d = '0;
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_d   = '0;
                        bit_d   = bit_q + 1'b1;
                        shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PAR: begin
                    if (bit_end) begin
                        cnt_d = '0;
                        par_d = rxs_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt_d = '0;
                        if (rxs_q) begin
                            dout_d  = shift_q;
                            valid_d = 1'b1;
                            perr_d  = par_bad;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    assign DOUT  = dout_q;
    assign VALID = valid_q;
    assign FERR  = ferr_q;
    assign PERR  = perr_q;
    assign BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one default instance and one even-parity instance, driven with
// directed frames; a frame-level outcome queue is checked against the outputs every cycle.
module tb_uart_rx;

    localparam int OS = 16;

    logic       CLK = 1'b0;
    logic       RN = 1'b1;
    logic       TICK = 1'b0;
    logic       rxd0 = 1'b1, rxd1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       v0, f0, p0, b0, v1, f1, p1, b1;

    int checks = 0;
    int errors = 0;
    int div = 1;
    int tcnt = 0;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] mdout[2];
    logic       pv[2];
    logic       pf[2];
    logic       v, f, p;
    logic [7:0] d;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0)) dut0 (
        .CLK(CLK), .RN(RN), .TICK(TICK), .RXD(rxd0),
        .DOUT(dout0), .VALID(v0), .FERR(f0), .PERR(p0), .BUSY(b0)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1)) dut1 (
        .CLK(CLK), .RN(RN), .TICK(TICK), .RXD(rxd1),
        .DOUT(dout1), .VALID(v1), .FERR(f1), .PERR(p1), .BUSY(b1)
    );

    always #5 CLK = ~CLK;

    // TICK changes on the falling edge so it is stable at every rising edge.
    always @(negedge CLK) begin
        if (tcnt >= div - 1) begin
            TICK = 1'b1;
            tcnt = 0;
        end else begin
            TICK = 1'b0;
            tcnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cmp(input int idx, input logic vv, input logic ff, input logic pp,
                       input logic [7:0] dd);
        exp_t  e;
        int    qsz;
        string s;
        s   = (idx == 0) ? "0" : "1";
        qsz = (idx == 0) ? q0.size() : q1.size();
        if (vv || ff) begin
            check({"excl", s}, {31'd0, vv & ff}, 0);
            check({"width", s}, {31'd0, (vv & pv[idx]) | (ff & pf[idx])}, 0);
            if (qsz == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected%s pulse valid=%0b ferr=%0b want none", s, vv, ff);
            end else begin
                if (idx == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                check({"kind", s}, {30'd0, vv, ff}, e.ferr ? 2'b01 : 2'b10);
                check({"perr", s}, {31'd0, pp}, {31'd0, e.perr & ~e.ferr});
                if (!e.ferr) mdout[idx] = e.data;
            end
        end else begin
            check({"perr_idle", s}, {31'd0, pp}, 0);
        end
        check({"dout", s}, {24'd0, dd}, {24'd0, mdout[idx]});
        pv[idx] = vv;
        pf[idx] = ff;
    endtask

    always @(negedge CLK) begin
        if (RN) begin
            cmp(0, v0, f0, p0, dout0);
            cmp(1, v1, f1, p1, dout1);
        end
    end

    task automatic wait_tick();
        do @(posedge CLK); while (TICK !== 1'b1);
    endtask

    task automatic drive(input int idx, input logic b);
        if (idx == 0) rxd0 = b;
        else          rxd1 = b;
    endtask

    // Sends one frame; abort_bit >= 0 pulses RN in the middle of that frame bit instead.
    task automatic send(input int idx, input logic [7:0] data, input logic has_par,
                        input logic pbit, input logic stop, input int abort_bit);
        logic [10:0] bits;
        int          n;
        exp_t        e;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        n = 9;
        if (has_par) begin
            bits[9] = pbit;
            n = 10;
        end
        bits[n] = stop;
        n = n + 1;
        if (abort_bit < 0) begin
            e.ferr = ~stop;
            e.perr = stop & has_par & (pbit ^ (^data));
            e.data = data;
            if (idx == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            drive(idx, bits[i]);
            if (i == abort_bit) begin
                repeat (OS / 2) wait_tick();
                @(negedge CLK);
                RN = 1'b0;
                drive(idx, 1'b1);
                mdout[0] = 8'h00;
                mdout[1] = 8'h00;
                pv[0] = 1'b0; pv[1] = 1'b0; pf[0] = 1'b0; pf[1] = 1'b0;
                #1;
                check("abort_dout", {24'd0, dout0}, 0);
                check("abort_valid", {31'd0, v0}, 0);
                check("abort_ferr", {31'd0, f0}, 0);
                check("abort_perr", {31'd0, p0}, 0);
                check("abort_busy", {31'd0, b0}, 0);
                repeat (3) @(negedge CLK);
                RN = 1'b1;
                return;
            end
            repeat (OS) wait_tick();
        end
        if (!stop) begin
            @(negedge CLK);
            drive(idx, 1'b1);
        end
    endtask

    task automatic wait_flag(input int idx, output logic ov, output logic of_,
                             output logic op, output logic [7:0] od);
        ov = 1'b0; of_ = 1'b0; op = 1'b0; od = 8'h00;
        for (int n = 0; n < 20000; n++) begin
            @(negedge CLK);
            if (idx == 0 ? (v0 | f0) : (v1 | f1)) begin
                ov  = (idx == 0) ? v0 : v1;
                of_ = (idx == 0) ? f0 : f1;
                op  = (idx == 0) ? p0 : p1;
                od  = (idx == 0) ? dout0 : dout1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL timeout%0d no pulse within 20000 cycles got none want pulse", idx);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish got timeout want finish");
        $fatal(1);
    end

    initial begin
        mdout[0] = 8'h00; mdout[1] = 8'h00;
        pv[0] = 1'b0; pv[1] = 1'b0; pf[0] = 1'b0; pf[1] = 1'b0;
        #2 RN = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_dout0", {24'd0, dout0}, 0);
        check("rst_valid0", {31'd0, v0}, 0);
        check("rst_ferr0", {31'd0, f0}, 0);
        check("rst_perr0", {31'd0, p0}, 0);
        check("rst_busy0", {31'd0, b0}, 0);
        check("rst_dout1", {24'd0, dout1}, 0);
        check("rst_busy1", {31'd0, b1}, 0);
        RN = 1'b1;
        repeat (5) @(negedge CLK);

        // Good 0x55 frame
        fork
            send(0, 8'h55, 1'b0, 1'b0, 1'b1, -1);
            wait_flag(0, v, f, p, d);
        join
        check("t55_valid", {31'd0, v}, 1);
        check("t55_ferr", {31'd0, f}, 0);
        check("t55_perr", {31'd0, p}, 0);
        check("t55_dout", {24'd0, d}, 8'h55);
        @(negedge CLK);
        check("t55_busy_after", {31'd0, b0}, 0);

        // Short low glitch in idle
        rxd0 = 1'b0;
        repeat (4) wait_tick();
        @(negedge CLK);
        check("glitch_busy_hi", {31'd0, b0}, 1);
        rxd0 = 1'b1;
        repeat (12) wait_tick();
        @(negedge CLK);
        check("glitch_busy_lo", {31'd0, b0}, 0);
        check("glitch_dout", {24'd0, dout0}, 8'h55);

        // Framing error after a good frame
        send(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
        fork
            send(0, 8'hA3, 1'b0, 1'b0, 1'b0, -1);
            wait_flag(0, v, f, p, d);
        join
        check("ferr_flag", {31'd0, f}, 1);
        check("ferr_valid", {31'd0, v}, 0);
        check("ferr_dout", {24'd0, d}, 8'h3C);
        repeat (30) wait_tick();
        @(negedge CLK);
        check("ferr_busy_after", {31'd0, b0}, 0);
        check("ferr_dout_after", {24'd0, dout0}, 8'h3C);

        // Even parity: 0xA3 has four ones, so parity bit 0 is correct
        fork
            send(1, 8'hA3, 1'b1, 1'b0, 1'b1, -1);
            wait_flag(1, v, f, p, d);
        join
        check("par_ok_valid", {31'd0, v}, 1);
        check("par_ok_perr", {31'd0, p}, 0);
        check("par_ok_dout", {24'd0, d}, 8'hA3);
        fork
            send(1, 8'hA3, 1'b1, 1'b1, 1'b1, -1);
            wait_flag(1, v, f, p, d);
        join
        check("par_bad_valid", {31'd0, v}, 1);
        check("par_bad_perr", {31'd0, p}, 1);
        check("par_bad_dout", {24'd0, d}, 8'hA3);

        // Back-to-back frames with TICK every 3 clocks
        div = 3;
        repeat (10) @(negedge CLK);
        fork
            begin
                send(0, 8'h01, 1'b0, 1'b0, 1'b1, -1);
                send(0, 8'hFF, 1'b0, 1'b0, 1'b1, -1);
            end
            begin
                wait_flag(0, v, f, p, d);
                check("b2b_first_valid", {31'd0, v}, 1);
                check("b2b_first_dout", {24'd0, d}, 8'h01);
                wait_flag(0, v, f, p, d);
                check("b2b_second_valid", {31'd0, v}, 1);
                check("b2b_second_dout", {24'd0, d}, 8'hFF);
            end
        join

        // Reset in data bit 4 of 0x5A, then a clean 0x81
        div = 1;
        repeat (10) @(negedge CLK);
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1, 5);
        repeat (5) @(negedge CLK);
        fork
            send(0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
            wait_flag(0, v, f, p, d);
        join
        check("post_rst_valid", {31'd0, v}, 1);
        check("post_rst_dout", {24'd0, d}, 8'h81);

        repeat (10) @(negedge CLK);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
